// File: rtl/w100_sched.sv
// Round-robin scheduler sharing one w100 core (G3 registered, then G0-G2 applied, G10 sampled).
// Optional golden-model self-check enabled by defining W100_SCHED_CHECK_EN.
module w100_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] vec,
    output logic [NREQ-1:0]   gnt,
    output logic              done,
    output logic [IDW-1:0]    done_id,
    output logic              result,
    output logic              core_g0,
    output logic              core_g1,
    output logic              core_g2,
    output logic              core_g3,
    input  logic              core_g10,
    output logic              mismatch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  cur;
    logic [IDW-1:0]  pick;
    logic            pick_vld;
    logic [3:0]      cur_vec;
    logic [NREQ-1:0] cur_onehot;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // The granted vector is read live; requesters hold it stable while granted.
    assign cur_vec    = 4'(vec >> {cur, 2'b00});
    assign cur_onehot = NREQ'(1) << cur;

    // Rotating priority: scan downward so the lowest offset from ptr wins last.
    always_comb begin
        logic [NREQ-1:0] sh;
        int              idx;
        pick     = '0;
        pick_vld = 1'b0;
        sh       = '0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sh = req >> idx;
            if (sh[0]) begin
                pick     = IDW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        done      = 1'b0;
        core_g0   = 1'b0;
        core_g1   = 1'b0;
        core_g2   = 1'b0;
        core_g3   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                gnt       = cur_onehot;
                core_g3   = cur_vec[3];
                state_nxt = EVAL;
            end
            EVAL: begin
                gnt       = cur_onehot;
                core_g0   = cur_vec[0];
                core_g1   = cur_vec[1];
                core_g2   = cur_vec[2];
                core_g3   = cur_vec[3];
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr     <= '0;
            cur     <= '0;
            done_id <= '0;
            result  <= 1'b0;
        end else begin
            if (state == IDLE && pick_vld) begin
                cur <= pick;
            end
            if (state == EVAL) begin
                result  <= core_g10;
                done_id <= cur;
            end
            if (state == DONE) begin
                ptr <= wrap_inc(cur);
            end
        end
    end

`ifdef W100_SCHED_CHECK_EN
    function automatic logic golden(input logic [3:0] v);
        return v[3] & ~(v[1] ? v[0] : v[2]);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else if (state == EVAL && core_g10 != golden(cur_vec)) begin
            mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_w100_sched.sv
// Randomized and directed bench for w100_sched with a behavioural w100 core and a
// transaction-level reference model of the scheduler.
module tb_w100_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef W100_SCHED_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req   = '0;
    logic [4*NREQ-1:0] vec   = '0;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [IDW-1:0]    done_id;
    logic              result;
    logic              core_g0, core_g1, core_g2, core_g3;
    logic              core_g10;
    logic              mismatch;
    logic              g7  = 1'b0;
    logic              inj = 1'b0;

    always #5 clock = ~clock;

    // Behavioural w100 core: G7 registers G3, G10 is combinational; inj forces a wrong answer.
    always_ff @(posedge clock) g7 <= core_g3;
    assign core_g10 = (g7 & ~(core_g1 ? core_g0 : core_g2)) ^ inj;

    w100_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .vec      (vec),
        .gnt      (gnt),
        .done     (done),
        .done_id  (done_id),
        .result   (result),
        .core_g0  (core_g0),
        .core_g1  (core_g1),
        .core_g2  (core_g2),
        .core_g3  (core_g3),
        .core_g10 (core_g10),
        .mismatch (mismatch)
    );

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    // Reference model: m_age is cycles since grant (-1 when no transaction is open).
    int m_age = -1;
    int m_cur = 0;
    int m_ptr = 0;
    int m_did = 0;
    bit m_res = 1'b0;
    bit m_mis = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    function automatic logic [3:0] vsel(input int i);
        return 4'(vec >> (4 * i));
    endfunction

    function automatic bit fref(input logic [3:0] v);
        return v[3] & ~(v[1] ? v[0] : v[2]);
    endfunction

    task automatic check_outputs();
        logic [3:0]      v;
        logic [3:0]      ecore;
        logic [NREQ-1:0] eg;
        v     = vsel(m_cur);
        eg    = (m_age == 0 || m_age == 1) ? (NREQ'(1) << m_cur) : '0;
        ecore = (m_age == 0) ? {v[3], 3'b000} : ((m_age == 1) ? v : 4'b0000);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("done", 32'(done), 32'(m_age == 2));
        chk("done_id", 32'(done_id), 32'(m_did));
        chk("result", 32'(result), 32'(m_res));
        chk("core", 32'({core_g3, core_g2, core_g1, core_g0}), 32'(ecore));
        chk("mismatch", 32'(mismatch), 32'(m_mis));
    endtask

    // Advance the model over the coming edge using the inputs now driven, then check.
    task automatic cycle();
        logic [3:0] v;
        v = vsel(m_cur);
        if (reset) begin
            m_age = -1; m_ptr = 0; m_cur = 0; m_did = 0; m_res = 1'b0; m_mis = 1'b0;
        end else if (m_age < 0) begin
            if (req != '0) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % NREQ]) m_cur = (m_ptr + k) % NREQ;
                end
                m_age = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (m_age == 1) begin
            m_res = fref(v) ^ inj;
            m_did = m_cur;
            if (CHK && inj) m_mis = 1'b1;
            m_age = 2;
        end else begin
            m_ptr = (m_cur + 1) % NREQ;
            m_age = -1;
        end
        @(negedge clock);
        ncyc++;
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req   = '1;
        repeat (n) begin
            cycle();
            chk("rst_gnt", 32'(gnt), 32'd0);
        end
        reset = 1'b0;
    endtask

    task automatic wait_first_grant(input int idx);
        int c;
        c = 0;
        while (gnt == '0 && c < 8) begin
            cycle();
            c++;
        end
        chk("first_gnt", 32'(gnt), 32'(NREQ'(1) << idx));
    endtask

    task automatic run_single(input int i, input logic [3:0] v, input bit exp_res, input bit inj_en);
        int gcnt;
        bit seen;
        gcnt = 0;
        seen = 1'b0;
        vec[4*i +: 4] = v;
        req = NREQ'(1) << i;
        for (int c = 0; c < 12 && !seen; c++) begin
            inj = inj_en && (m_age == 1);
            cycle();
            if (gnt == (NREQ'(1) << i)) gcnt++;
            if (done) begin
                seen = 1'b1;
                req  = '0;
                inj  = 1'b0;
                chk("single_id", 32'(done_id), 32'(i));
                chk("single_res", 32'(result), 32'(exp_res));
            end
        end
        inj = 1'b0;
        chk("single_seen", 32'(seen), 32'd1);
        chk("single_gntcyc", 32'(gcnt), 32'd2);
        cycle();
    endtask

    task automatic fair_drive();
        if (done) req[done_id] = 1'b0;
        else      req = '1;
    endtask

    initial begin
        int ids[$];
        int tdone[$];

        do_reset(2);
        wait_first_grant(0);
        req = '0;
        repeat (4) cycle();

        run_single(2, 4'b1010, 1'b1, 1'b0);
        run_single(0, 4'b1000, 1'b1, 1'b0);
        run_single(0, 4'b1011, 1'b0, 1'b0);
        run_single(0, 4'b1100, 1'b0, 1'b0);
        run_single(0, 4'b0001, 1'b0, 1'b0);

        do_reset(2);
        for (int i = 0; i < NREQ; i++) vec[4*i +: 4] = 4'(4'b1000 + i);
        for (int c = 0; c < 40 && ids.size() < 5; c++) begin
            cycle();
            if (done) begin
                ids.push_back(int'(done_id));
                tdone.push_back(ncyc);
            end
            fair_drive();
        end
        chk("fair_count", 32'(ids.size()), 32'd5);
        for (int k = 0; k < ids.size(); k++) begin
            chk("fair_id", 32'(ids[k]), 32'(k % NREQ));
            if (k > 0) chk("fair_gap", 32'(tdone[k] - tdone[k-1]), 32'd4);
        end

        for (int c = 0; c < 40; c++) begin
            if (m_age == 1 && m_cur == 1) break;
            cycle();
            fair_drive();
        end
        chk("mid_in_eval", 32'(gnt), 32'b0010);
        reset = 1'b1;
        cycle();
        chk("mid_gnt", 32'(gnt), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        reset = 1'b0;
        req   = '1;
        wait_first_grant(0);
        req = '0;
        repeat (4) cycle();

        for (int c = 0; c < 400; c++) begin
            req = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (!((m_age == 0 || m_age == 1) && i == m_cur))
                    vec[4*i +: 4] = 4'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 1'b0;
        req   = '0;
        repeat (4) cycle();

        do_reset(2);
        req = '0;
        repeat (4) cycle();
        run_single(0, 4'b1000, 1'b0, 1'b1);
        chk("mis_set", 32'(mismatch), 32'(CHK));
        repeat (3) cycle();
        run_single(1, 4'b1000, 1'b1, 1'b0);
        chk("mis_sticky", 32'(mismatch), 32'(CHK));
        do_reset(1);
        req = '0;
        cycle();
        chk("mis_clear", 32'(mismatch), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/w100_sched.md
# w100_sched

Round-robin scheduler that time-shares one w100 netlist instance (4 inputs G0–G3, registered G3 path, output G10) between NREQ requesters. Each requester submits a 4-bit vector {G3,G2,G1,G0}. The scheduler sequences the core's two-phase evaluation: G3 is loaded into the core's internal register, then G0–G2 are applied and G10 is sampled. The captured result returns to the granted requester. The block sits between the bench-level stimulus agents and the single shared w100 core.

## Interface
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must satisfy 2^IDW >= NREQ.
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- vec  in  4*NREQ  per-requester vector; bits [4i+3:4i] = {G3,G2,G1,G0} of requester i.
- gnt  out  NREQ  one-hot grant; at most one bit set.
- done  out  1  one-cycle pulse; result valid.
- done_id  out  IDW  index of the requester that owns `result`.
- result  out  1  captured G10 for the completed transaction.
- core_g0, core_g1, core_g2, core_g3  out  1 each  drive the shared w100 core inputs.
- core_g10  in  1  w100 core output (combinational from G0–G2 and internal G7).
- mismatch  out  1  sticky self-check flag (see Configuration).

## Operation
- FSM states: IDLE, LOAD, EVAL, DONE. The state register is encoded in 2 bits.
- IDLE: if any `req` bit is set, choose the first set bit at or after `ptr`, scanning upward with wrap-around. Latch its index into `cur`. Go to LOAD. With no request, stay in IDLE.
- LOAD: `gnt[cur]`=1. `core_g3`=vec[4*cur+3]; core_g0..g2 = 0. Always go to EVAL. The core's G7 captures G3 at this edge.
- EVAL: `gnt[cur]`=1. core_g0..g3 = vec[4*cur+3:4*cur]. At the edge, `result` <= core_g10 and `done_id` <= cur. Go to DONE.
- DONE: `done`=1, `gnt`=0, core inputs all 0. `ptr` <= cur+1, wrapping to 0 after NREQ-1. Always go to IDLE.
- Core inputs are all 0 in IDLE and DONE.
- `vec` of the granted requester must be stable while its `gnt` is high. The scheduler reads it live, not latched.
- Deasserting `req` while granted does not abort; the transaction completes and `done` still pulses.
- A requester must drop `req` in the cycle it sees `done` for its index, or it is eligible again and is re-granted only after higher-priority requesters are served under the rotated pointer.
- `result` and `done_id` hold their values until the next EVAL capture.

## Timing
- Reset values: state=IDLE, ptr=0, cur=0, gnt=0, done=0, done_id=0, result=0, all core_g*=0, mismatch=0.
- Latency: `req` high at edge N (state IDLE) gives gnt at N+1 to N+3, done high at N+3 to N+4, back in IDLE at N+4.
- Throughput: one transaction per 4 cycles under continuous load.
- Reset asserted in any state takes effect at the next edge. The in-flight transaction is aborted with no `done`, and the pointer returns to 0.
- Simultaneous requests: only the pointer decides. With all NREQ requesting continuously, grants cycle 0,1,…,NREQ-1,0.
- A `req` that rises during LOAD/EVAL/DONE waits for the next IDLE.

## Configuration
- W100_SCHED_CHECK_EN defined: an internal golden model computes exp = vec3 & ~(vec1 ? vec0 : vec2) for the granted vector in EVAL. If core_g10 != exp at the EVAL edge, `mismatch` <= 1. It stays sticky until reset.
- W100_SCHED_CHECK_EN undefined: no golden-model logic is built, and `mismatch` is tied to 0.

## Test plan
- Reset: hold reset 2 cycles with req=4'b1111. Required: all outputs 0, no gnt. After release, first grant goes to requester 0.
- Single request: requester 2 with vec=4'b1010 (G3=1, G1=1, G0=0). Required: gnt=4'b0100 for 2 cycles, then done=1, done_id=2, result=1.
- Function values (requester 0):
  - 4'b1000 gives 1.
  - 4'b1011 gives 0.
  - 4'b1100 gives 0.
  - 4'b0001 gives 0.
  - In every case with W100_SCHED_CHECK_EN defined, mismatch stays 0.
- Fairness: all four req held high (dropped on their own done, then re-raised). Required: done_id sequence 0,1,2,3,0, with done spaced exactly 4 cycles apart.
- Reset mid-operation: assert reset during EVAL of requester 1. Required: no done pulse, gnt=0 next cycle, ptr=0, and the next grant goes to requester 0.
- Self-check: with W100_SCHED_CHECK_EN defined, force core_g10 to an inverted value for one transaction. Required: mismatch=1 from the cycle after that EVAL and remaining 1 until reset.
